// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, register-file addressing and
// the common word / register-address types used by the writeback stage.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic        [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic signed [XLEN-1:0]       word_t;
    typedef logic        [NUM_REGS-1:0]   reg_mask_t;

    // One-hot mask selecting a single architectural register.
    function automatic reg_mask_t reg_onehot(input reg_addr_t rd);
        reg_mask_t m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Synchronous FIFO of load destination registers, held in issue order so
// each returning load response can be matched to its destination.
module rd_tag_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  reg_addr_t din,
    output reg_addr_t dout,
    output logic      full,
    output logic      empty
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW:0]     CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]     FULL_CNT = (PW + 1)'(DEPTH);

    reg_addr_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state: pointers and count, cleared by reset so the queue empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Tag storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results, a one-entry load hold buffer and
// fresh load responses onto a single registered register-file write port,
// and keeps a scoreboard of registers awaiting load data.
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      alu_valid,
    input  reg_addr_t alu_rd,
    input  word_t     alu_data,
    input  logic      ld_issue,
    input  reg_addr_t ld_issue_rd,
    output logic      ld_issue_ready,
    input  logic      ld_resp_valid,
    input  word_t     ld_resp_data,
    output logic      ld_resp_ready,
    input  reg_addr_t q_rs1,
    input  reg_addr_t q_rs2,
    output logic      busy_rs1,
    output logic      busy_rs2,
    output logic      wb_en,
    output reg_addr_t wb_rd,
    output word_t     wb_data,
    output logic      err_orphan
);

    reg_mask_t pending_q, pending_d;
    logic      hold_valid_q, hold_valid_d;
    reg_addr_t hold_rd_q, hold_rd_d;
    word_t     hold_data_q, hold_data_d;
    logic      wb_en_q, wb_en_d;
    reg_addr_t wb_rd_q, wb_rd_d;
    word_t     wb_data_q, wb_data_d;
    logic      orphan_q, orphan_d;

    logic      fifo_full, fifo_empty;
    reg_addr_t head_rd;
    logic      resp_acc, tag_pop, tag_push, orphan_now;
    reg_mask_t set_mask, clr_mask;

    // Pre-pop fullness gates issue; a full queue stalls issue even if a pop occurs.
    assign ld_issue_ready = !fifo_full;
    assign ld_resp_ready  = !hold_valid_q;
    assign resp_acc       = ld_resp_valid && !hold_valid_q;
    assign tag_pop        = resp_acc && !fifo_empty;
    assign orphan_now     = resp_acc && fifo_empty;
    assign tag_push       = ld_issue && !fifo_full;

    assign busy_rs1   = (q_rs1 != '0) && pending_q[q_rs1];
    assign busy_rs2   = (q_rs2 != '0) && pending_q[q_rs2];
    assign wb_en      = wb_en_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign err_orphan = orphan_q;

    rd_tag_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (ld_issue_rd),
        .dout  (head_rd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration ALU > hold > new response, plus scoreboard set/clear.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        wb_en_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        clr_mask     = '0;
        set_mask     = '0;
        orphan_d     = orphan_q || orphan_now;

        if (alu_valid) begin
            wb_en_d   = (alu_rd != '0);
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
            // A response accepted alongside the ALU result is parked for next cycle.
            if (tag_pop) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = head_rd;
                hold_data_d  = ld_resp_data;
            end
        end else if (hold_valid_q) begin
            wb_en_d      = (hold_rd_q != '0);
            wb_rd_d      = hold_rd_q;
            wb_data_d    = hold_data_q;
            clr_mask     = reg_onehot(hold_rd_q);
            hold_valid_d = 1'b0;
        end else if (tag_pop) begin
            wb_en_d   = (head_rd != '0);
            wb_rd_d   = head_rd;
            wb_data_d = ld_resp_data;
            clr_mask  = reg_onehot(head_rd);
        end

        if (tag_push && (ld_issue_rd != '0)) begin
            set_mask = reg_onehot(ld_issue_rd);
        end
        // Set after clear so a same-cycle re-issue keeps the register busy.
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // All writeback state is discarded on reset; no write escapes after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            orphan_q     <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            orphan_q     <= orphan_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, load path, arbitration via the
// hold buffer, tag-queue fill, x0 handling, orphan responses and reset.
module tb_writeback_unit;
    import cpu_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      alu_valid;
    reg_addr_t alu_rd;
    word_t     alu_data;
    logic      ld_issue;
    reg_addr_t ld_issue_rd;
    logic      ld_issue_ready;
    logic      ld_resp_valid;
    word_t     ld_resp_data;
    logic      ld_resp_ready;
    reg_addr_t q_rs1, q_rs2;
    logic      busy_rs1, busy_rs2;
    logic      wb_en;
    reg_addr_t wb_rd;
    word_t     wb_data;
    logic      err_orphan;

    int total = 0;
    int bad   = 0;

    writeback_unit #(
        .LQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue       (ld_issue),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .ld_resp_ready  (ld_resp_ready),
        .q_rs1          (q_rs1),
        .q_rs2          (q_rs2),
        .busy_rs1       (busy_rs1),
        .busy_rs2       (busy_rs2),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .err_orphan     (err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid     = 1'b0;
        alu_rd        = '0;
        alu_data      = '0;
        ld_issue      = 1'b0;
        ld_issue_rd   = '0;
        ld_resp_valid = 1'b0;
        ld_resp_data  = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wb_en"},   32'(wb_en), 32'd0);
        chk({tag, "_wb_rd"},   32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_iss_rdy"}, 32'(ld_issue_ready), 32'd1);
        chk({tag, "_rsp_rdy"}, 32'(ld_resp_ready), 32'd1);
        chk({tag, "_orphan"},  32'(err_orphan), 32'd0);
        chk({tag, "_busy1"},   32'(busy_rs1), 32'd0);
        chk({tag, "_busy2"},   32'(busy_rs2), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        q_rs1 = '0;
        q_rs2 = '0;
        idle();
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;
        tick();

        // ALU write rd=5, data=-7, visible for exactly one cycle
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = -32'sd7;
        tick();
        idle();
        chk("alu_en",   32'(wb_en), 32'd1);
        chk("alu_rd",   32'(wb_rd), 32'd5);
        chk("alu_data", wb_data, 32'hFFFF_FFF9);
        tick();
        chk("alu_once", 32'(wb_en), 32'd0);

        // Load rd=9, response three cycles after issue
        q_rs1 = 5'd9;
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        #1;
        chk("ld9_pre_busy", 32'(busy_rs1), 32'd0);
        tick();
        idle();
        chk("ld9_busy_iss1", 32'(busy_rs1), 32'd1);
        tick();
        tick();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_1234;
        #1;
        chk("ld9_busy_resp", 32'(busy_rs1), 32'd1);
        chk("ld9_rsp_rdy",   32'(ld_resp_ready), 32'd1);
        tick();
        idle();
        chk("ld9_en",    32'(wb_en), 32'd1);
        chk("ld9_rd",    32'(wb_rd), 32'd9);
        chk("ld9_data",  wb_data, 32'h0000_1234);
        chk("ld9_clear", 32'(busy_rs1), 32'd0);
        tick();
        chk("ld9_once", 32'(wb_en), 32'd0);

        // Response loses to ALU, goes through the hold register
        q_rs1 = 5'd3;
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        tick();
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'd10;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'sd20;
        tick();
        idle();
        chk("arb_alu_rd",    32'(wb_rd), 32'd4);
        chk("arb_alu_data",  wb_data, 32'd20);
        chk("arb_alu_en",    32'(wb_en), 32'd1);
        chk("arb_rdy_low",   32'(ld_resp_ready), 32'd0);
        chk("arb_busy_held", 32'(busy_rs1), 32'd1);
        tick();
        chk("arb_hold_en",   32'(wb_en), 32'd1);
        chk("arb_hold_rd",   32'(wb_rd), 32'd3);
        chk("arb_hold_data", wb_data, 32'd10);
        chk("arb_rdy_back",  32'(ld_resp_ready), 32'd1);
        chk("arb_busy_clr",  32'(busy_rs1), 32'd0);
        tick();
        chk("arb_quiet", 32'(wb_en), 32'd0);

        // Fill the tag queue with rd 1..4
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("fill_rdy_%0d", i), 32'(ld_issue_ready), 32'd1);
            ld_issue = 1'b1; ld_issue_rd = 5'(i);
            tick();
        end
        idle();
        chk("fill_full", 32'(ld_issue_ready), 32'd0);
        q_rs1 = 5'd1; q_rs2 = 5'd4;
        #1;
        chk("fill_busy1", 32'(busy_rs1), 32'd1);
        chk("fill_busy4", 32'(busy_rs2), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            ld_resp_valid = 1'b1; ld_resp_data = 32'h100 + 32'(i);
            tick();
            if (i == 1) chk("fill_rdy_recover", 32'(ld_issue_ready), 32'd1);
            chk($sformatf("drain_en_%0d", i),   32'(wb_en), 32'd1);
            chk($sformatf("drain_rd_%0d", i),   32'(wb_rd), 32'(i));
            chk($sformatf("drain_data_%0d", i), wb_data, 32'h100 + 32'(i));
        end
        idle();
        #1;
        chk("drain_busy1", 32'(busy_rs1), 32'd0);
        chk("drain_busy4", 32'(busy_rs2), 32'd0);
        tick();
        chk("drain_quiet", 32'(wb_en), 32'd0);

        // x0 destinations: never written, never busy, tag still consumed
        q_rs1 = 5'd0;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        tick();
        idle();
        chk("x0_busy", 32'(busy_rs1), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd1;
        tick();
        idle();
        chk("x0_alu_en", 32'(wb_en), 32'd0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h55;
        tick();
        idle();
        chk("x0_ld_en", 32'(wb_en), 32'd0);
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        tick();
        idle();
        chk("x0_popped_en",   32'(wb_en), 32'd1);
        chk("x0_popped_rd",   32'(wb_rd), 32'd7);
        chk("x0_popped_data", wb_data, 32'h77);
        chk("x0_no_orphan",   32'(err_orphan), 32'd0);

        // Orphan response with empty queue
        ld_resp_valid = 1'b1; ld_resp_data = 32'hDEAD;
        tick();
        idle();
        chk("orph_en",  32'(wb_en), 32'd0);
        chk("orph_set", 32'(err_orphan), 32'd1);
        tick();
        chk("orph_sticky", 32'(err_orphan), 32'd1);

        // Reset with two loads in flight
        q_rs1 = 5'd10; q_rs2 = 5'd11;
        ld_issue = 1'b1; ld_issue_rd = 5'd10;
        tick();
        ld_issue_rd = 5'd11;
        tick();
        idle();
        chk("pre_rst_busy10", 32'(busy_rs1), 32'd1);
        chk("pre_rst_busy11", 32'(busy_rs2), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst = 1'b0;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h99;
        tick();
        idle();
        chk("post_rst_nowrite", 32'(wb_en), 32'd0);
        chk("post_rst_orphan",  32'(err_orphan), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
